// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths and the buffered write request type for the register-file
// write-port arbiter.
package wb_arb_pkg;
    localparam int REG_COUNT = 8;
    localparam int ADDR_W    = 3;
    localparam int DATA_W    = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    function automatic logic [REG_COUNT-1:0] reg_onehot(input logic [ADDR_W-1:0] a);
        return {{(REG_COUNT-1){1'b0}}, 1'b1} << a;
    endfunction
endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback bus between the pipeline, the multi-cycle result source and the
// register file write port; slave is the arbiter side.
interface wb_port_arbiter_if;
    import wb_arb_pkg::*;

    logic                 p_valid;
    logic [ADDR_W-1:0]    p_addr;
    logic [DATA_W-1:0]    p_data;
    logic                 m_valid;
    logic                 m_ready;
    logic [ADDR_W-1:0]    m_addr;
    logic [DATA_W-1:0]    m_data;
    logic                 rf_we;
    logic [ADDR_W-1:0]    rf_a3;
    logic [DATA_W-1:0]    rf_wd3;
    logic [REG_COUNT-1:0] pending_mask;
    logic                 stall_req;

    modport slave (
        input  p_valid, p_addr, p_data, m_valid, m_addr, m_data,
        output m_ready, rf_we, rf_a3, rf_wd3, pending_mask, stall_req
    );

    modport master (
        output p_valid, p_addr, p_data, m_valid, m_addr, m_data,
        input  m_ready, rf_we, rf_a3, rf_wd3, pending_mask, stall_req
    );
endinterface

// File: rtl/wb_port_arbiter_fifo.sv
// Power-of-two result buffer; exposes every slot and its valid bit so the
// arbiter can build the pending-write mask.
module wb_fifo
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  wb_req_t                  din_i,
    output wb_req_t                  head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [DEPTH-1:0]         valid_o,
    output wb_req_t                  mem_o [DEPTH]
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_req_t            mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push_ok, pop_ok;
    logic [PTR_W-1:0]   off;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

    always_comb begin
        valid_o = '0;
        off     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off        = PTR_W'(i) - rd_ptr_q;
            valid_o[i] = ({1'b0, off} < count_q);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign mem_o   = mem_q;
endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has fixed priority,
// multi-cycle results queue in wb_fifo. WBARB_STARVE_EN adds a stall request.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    wb_port_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_param
        $error("wb_port_arbiter: DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
    end

    wb_req_t            head;
    wb_req_t            slots [DEPTH];
    logic [DEPTH-1:0]   slot_vld;
    logic [CNT_W-1:0]   count;
    logic               full, empty, push, pop;

    assign push        = bus.m_valid && !full;
    assign pop         = !bus.p_valid && !empty;
    assign bus.m_ready = (count < CNT_W'(DEPTH));

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   ({bus.m_addr, bus.m_data}),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count),
        .valid_o (slot_vld),
        .mem_o   (slots)
    );

    always_comb begin
        bus.rf_we  = 1'b0;
        bus.rf_a3  = '0;
        bus.rf_wd3 = '0;
        if (bus.p_valid) begin
            bus.rf_we  = 1'b1;
            bus.rf_a3  = bus.p_addr;
            bus.rf_wd3 = bus.p_data;
        end else if (!empty) begin
            bus.rf_we  = 1'b1;
            bus.rf_a3  = head.addr;
            bus.rf_wd3 = head.data;
        end
    end

    always_comb begin
        bus.pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_vld[i]) bus.pending_mask = bus.pending_mask | reg_onehot(slots[i].addr);
        end
    end

`ifdef WBARB_STARVE_EN
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    logic [SC_W-1:0] starve_q, starve_d;
    logic            stall_q, stall_d;

    // Counts edges where a buffered write was blocked by P; saturates at the limit.
    always_comb begin
        starve_d = starve_q;
        stall_d  = stall_q;
        if (pop || empty) begin
            starve_d = '0;
        end else if (bus.p_valid && starve_q != SC_W'(STARVE_LIMIT)) begin
            starve_d = starve_q + SC_W'(1);
        end
        if (pop) begin
            stall_d = 1'b0;
        end else if (starve_d == SC_W'(STARVE_LIMIT)) begin
            stall_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    assign bus.stall_req = stall_q;
`else
    assign bus.stall_req = 1'b0;
`endif
endmodule
